// File: rtl/fetch_pc_ir_unit.sv
// fetch_pc_ir_unit: owns the PC and IR, runs the IDLE/WAIT instruction fetch
// handshake and freezes the control FSM while a fetch is outstanding.
// Optional build macro: FETCH_TIMEOUT_EN enables a WAIT-state watchdog that
// abandons a fetch after TIMEOUT cycles, loads a NOP and sets fetch_fault.
module fetch_pc_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_WE,
  input  logic        IR_WE,
  input  logic [1:0]  PCSrc,
  input  logic        BEN,
  input  logic        BEQBNE,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out_reg,
  input  logic [31:0] reg_a,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        stall,
  output logic        ir_valid,
  output logic        misalign,
  output logic        fetch_fault
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] fetch_addr_reg;
  logic        ir_valid_reg;
  logic        misalign_reg;

  logic        load_ir;
  logic [31:0] load_data;
  logic        timeout_hit;
  logic        branch_taken;
  logic        pc_wr;
  logic [31:0] pc_next;

  // A watchdog shorter than one cycle cannot be honoured; guard the range.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("TIMEOUT must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] wait_cnt_reg;
  logic        fault_reg;
`endif

  assign pc_plus4    = pc_reg + 32'd4;
  assign pc          = pc_reg;
  assign instruction = ir_reg;
  assign ir_valid    = ir_valid_reg;
  assign misalign    = misalign_reg;

  // Fetch handshake: request/address/stall and IR-load decision per state.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_reg;
    stall       = 1'b0;
    load_ir     = 1'b0;
    load_data   = imem_rdata;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        imem_req = IR_WE;
        if (IR_WE) begin
          if (imem_valid) load_ir = 1'b1;
          else            stall   = 1'b1;
        end
      end
      default: begin
        imem_req  = 1'b1;
        imem_addr = fetch_addr_reg;
        if (imem_valid) begin
          load_ir = 1'b1;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          if (wait_cnt_reg == 16'(TIMEOUT - 1)) begin
            // Give up: hand the decoder a NOP and let the control FSM move on.
            timeout_hit = 1'b1;
            load_ir     = 1'b1;
            load_data   = 32'h0000_0000;
          end else begin
            stall = 1'b1;
          end
`else
          stall = 1'b1;
`endif
        end
      end
    endcase
  end

  // Next-PC selection and the write qualifier (never while stalled).
  always_comb begin
    branch_taken = BEN & (alu_zero ^ BEQBNE);
    pc_wr        = (PC_WE | branch_taken) & ~stall;
    case (PCSrc)
      2'd0:    pc_next = alu_out_reg;
      2'd1:    pc_next = {pc_plus4[31:28], ir_reg[25:0], 2'b00};
      2'd2:    pc_next = alu_result;
      default: pc_next = reg_a;
    endcase
  end

  // Fetch FSM, PC, IR and the sticky misalignment flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= RESET_PC;
      ir_reg         <= 32'h0000_0000;
      fetch_addr_reg <= 32'h0000_0000;
      ir_valid_reg   <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      ir_valid_reg <= load_ir;
      if (load_ir) ir_reg <= load_data;
      if (pc_wr)   pc_reg <= pc_next;
      if (imem_req && (imem_addr[1:0] != 2'b00)) misalign_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: if (IR_WE && !imem_valid) begin
          state_reg      <= ST_WAIT;
          fetch_addr_reg <= pc_reg;
        end
        default: if (load_ir) state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Watchdog: counts WAIT cycles, restarts on each entry to WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= 16'd0;
      fault_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE) wait_cnt_reg <= 16'd0;
      else if (!load_ir)        wait_cnt_reg <= wait_cnt_reg + 16'd1;
      if (timeout_hit) fault_reg <= 1'b1;
    end
  end
  assign fetch_fault = fault_reg;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_ir_unit.sv
// Directed, table-driven bench for fetch_pc_ir_unit plus hand-written
// sequences for reset-during-WAIT and (when FETCH_TIMEOUT_EN) the watchdog.
module tb_fetch_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_WE, IR_WE, BEN, BEQBNE, alu_zero, imem_valid;
  logic [1:0]  PCSrc;
  logic [31:0] alu_result, alu_out_reg, reg_a, imem_rdata;
  logic        imem_req, stall, ir_valid, misalign, fetch_fault;
  logic [31:0] imem_addr, instruction, pc, pc_plus4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_pc_ir_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .PC_WE(PC_WE), .IR_WE(IR_WE), .PCSrc(PCSrc),
    .BEN(BEN), .BEQBNE(BEQBNE), .alu_zero(alu_zero), .alu_result(alu_result),
    .alu_out_reg(alu_out_reg), .reg_a(reg_a), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .ir_valid(ir_valid), .misalign(misalign), .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic        ir_we, pc_we;
    logic [1:0]  src;
    logic        ben, bne, zero, valid;
    logic [31:0] alu_result, alu_out, reg_a, rdata;
    logic        exp_req, exp_stall;
    logic [31:0] exp_addr, exp_pc, exp_instr;
    logic        exp_irv, exp_mis;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(
    input logic ir_we, input logic pc_we, input logic [1:0] src,
    input logic ben, input logic bne, input logic zero, input logic valid,
    input logic [31:0] ar, input logic [31:0] ao, input logic [31:0] ra,
    input logic [31:0] rd, input logic ereq, input logic estall,
    input logic [31:0] eaddr, input logic [31:0] epc, input logic [31:0] eir,
    input logic eirv, input logic emis);
    vec_t v;
    v.ir_we = ir_we; v.pc_we = pc_we; v.src = src; v.ben = ben; v.bne = bne;
    v.zero = zero; v.valid = valid; v.alu_result = ar; v.alu_out = ao;
    v.reg_a = ra; v.rdata = rd; v.exp_req = ereq; v.exp_stall = estall;
    v.exp_addr = eaddr; v.exp_pc = epc; v.exp_instr = eir; v.exp_irv = eirv;
    v.exp_mis = emis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    IR_WE = v.ir_we; PC_WE = v.pc_we; PCSrc = v.src; BEN = v.ben;
    BEQBNE = v.bne; alu_zero = v.zero; imem_valid = v.valid;
    alu_result = v.alu_result; alu_out_reg = v.alu_out; reg_a = v.reg_a;
    imem_rdata = v.rdata;
  endtask

  task automatic idle_inputs();
    IR_WE = 0; PC_WE = 0; PCSrc = 0; BEN = 0; BEQBNE = 0; alu_zero = 0;
    imem_valid = 0; alu_result = 0; alu_out_reg = 0; reg_a = 0; imem_rdata = 0;
  endtask

  initial begin
    //            irw pcw src ben bne z  vld alu_result    alu_out       reg_a         rdata          req stl addr          pc            instr         irv mis
    vecs[0]  = mk(1, 1, 2, 0, 0, 0, 1, 32'h4,        32'h0,        32'h0,        32'h2008_0005, 1, 0, 32'h0,        32'h4,        32'h2008_0005, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,         0, 0, 32'h4,        32'h4,        32'h2008_0005, 0, 0);
    vecs[2]  = mk(0, 1, 3, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,         0, 0, 32'h4,        32'h0,        32'h2008_0005, 0, 0);
    vecs[3]  = mk(1, 1, 2, 0, 0, 0, 0, 32'h4,        32'h0,        32'h0,        32'h0,         1, 1, 32'h0,        32'h0,        32'h2008_0005, 0, 0);
    vecs[4]  = mk(1, 1, 2, 0, 0, 0, 0, 32'h4,        32'h0,        32'h0,        32'hDEAD,      1, 1, 32'h0,        32'h0,        32'h2008_0005, 0, 0);
    vecs[5]  = mk(1, 1, 2, 0, 0, 0, 0, 32'h4,        32'h0,        32'h0,        32'hBEEF,      1, 1, 32'h0,        32'h0,        32'h2008_0005, 0, 0);
    vecs[6]  = mk(1, 1, 2, 0, 0, 0, 1, 32'h4,        32'h0,        32'h0,        32'hAABB_CCDD, 1, 0, 32'h0,        32'h4,        32'hAABB_CCDD, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,         0, 0, 32'h4,        32'h4,        32'hAABB_CCDD, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 1, 0, 32'h0,        32'h40,       32'h0,        32'h0,         0, 0, 32'h4,        32'h40,       32'hAABB_CCDD, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h80,       32'h0,        32'h0,         0, 0, 32'h40,       32'h40,       32'hAABB_CCDD, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 1, 0, 0, 32'h0,        32'h80,       32'h0,        32'h0,         0, 0, 32'h40,       32'h80,       32'hAABB_CCDD, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 1, 1, 0, 32'h0,        32'h100,      32'h0,        32'h0,         0, 0, 32'h80,       32'h80,       32'hAABB_CCDD, 0, 0);
    vecs[12] = mk(0, 1, 3, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1000_0000, 32'h0,        0, 0, 32'h80,       32'h1000_0000, 32'hAABB_CCDD, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0800_0010, 1, 0, 32'h1000_0000, 32'h1000_0000, 32'h0800_0010, 1, 0);
    vecs[14] = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,         0, 0, 32'h1000_0000, 32'h1000_0040, 32'h0800_0010, 0, 0);
    vecs[15] = mk(0, 1, 3, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,        0, 0, 32'h1000_0040, 32'hFFFF_FFFC, 32'h0800_0010, 0, 0);
    vecs[16] = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,         0, 0, 32'hFFFF_FFFC, 32'h40,       32'h0800_0010, 0, 0);
    vecs[17] = mk(1, 0, 0, 1, 0, 1, 0, 32'h0,        32'h100,      32'h0,        32'h0,         1, 1, 32'h40,       32'h40,       32'h0800_0010, 0, 0);
    vecs[18] = mk(1, 0, 0, 1, 0, 1, 1, 32'h0,        32'h100,      32'h0,        32'h1234_5678, 1, 0, 32'h40,       32'h100,      32'h1234_5678, 1, 0);
    vecs[19] = mk(0, 1, 3, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2,        32'h0,         0, 0, 32'h100,      32'h2,        32'h1234_5678, 0, 0);
    vecs[20] = mk(1, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,         1, 0, 32'h2,        32'h2,        32'h0,         1, 1);
    vecs[21] = mk(0, 1, 3, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        32'h0,         0, 0, 32'h2,        32'h8,        32'h0,         0, 1);

    reset = 1'b0;
    idle_inputs();
    #1;
    $display("reset: pc=%08h ir=%08h", pc, instruction);
    check("reset_pc", pc, 32'h0);
    check("reset_pc_plus4", pc_plus4, 32'h4);
    check("reset_ir", instruction, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_flags", {28'h0, imem_req, stall, ir_valid, misalign}, 32'h0);
    check("reset_fault", {31'h0, fetch_fault}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
      check($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].exp_stall});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      check($sformatf("v%0d_ir", i), instruction, vecs[i].exp_instr);
      check($sformatf("v%0d_irv", i), {31'h0, ir_valid}, {31'h0, vecs[i].exp_irv});
      check($sformatf("v%0d_mis", i), {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
      check($sformatf("v%0d_fault", i), {31'h0, fetch_fault}, 32'h0);
      $display("vec %0d: pc=%08h ir=%08h stall=%0b irv=%0b mis=%0b",
               i, pc, instruction, stall, ir_valid, misalign);
      @(negedge clk);
    end

    // Reset while a fetch is pending, then a stale imem_valid arrives.
    idle_inputs();
    IR_WE = 1;
    @(posedge clk);
    @(negedge clk);
    check("wait_entered_stall", {31'h0, stall}, 32'h1);
    reset = 1'b0;
    #1;
    check("midreset_pc", pc, 32'h0);
    check("midreset_ir", instruction, 32'h0);
    check("midreset_mis", {31'h0, misalign}, 32'h0);
    IR_WE = 0;
    #1;
    check("midreset_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    imem_valid = 1; imem_rdata = 32'hFFFF_FFFF;
    #2;
    check("stale_req", {31'h0, imem_req}, 32'h0);
    check("stale_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    check("stale_irv", {31'h0, ir_valid}, 32'h0);
    check("stale_ir", instruction, 32'h0);
    check("stale_pc", pc, 32'h0);
    $display("midreset: pc=%08h ir=%08h irv=%0b", pc, instruction, ir_valid);
    @(negedge clk);
    imem_valid = 0;

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: fetch never completes; 1 IDLE + 16 WAIT cycles.
    IR_WE = 1; PC_WE = 1; PCSrc = 2; alu_result = 32'h20;
    for (int n = 1; n <= 17; n++) begin
      #2;
      check($sformatf("to_stall_%0d", n), {31'h0, stall}, (n < 17) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    check("to_fault", {31'h0, fetch_fault}, 32'h1);
    check("to_irv_late", {31'h0, ir_valid}, 32'h1);
    check("to_ir", instruction, 32'h0);
    check("to_pc", pc, 32'h20);
    $display("timeout: fault=%0b ir=%08h pc=%08h", fetch_fault, instruction, pc);
    idle_inputs();
    imem_valid = 1;
    @(posedge clk);
    #1;
    check("to_late_valid_irv", {31'h0, ir_valid}, 32'h0);
    check("to_fault_sticky", {31'h0, fetch_fault}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
